hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the five-stage core.
- Decides each cycle whether fetch (PC register) and the D-stage register advance, and whether a bubble is injected into E.
- Combines Tuse/Tnew data-hazard detection with a multi-cycle MUL/DIV busy tracker.
- Drives the PC `enable` input of the fetch unit, the IF/ID register enable and the ID/EX flush.

---
 rtl/hazard_ctrl_pkg.sv | 46 ++++
 rtl/hazard_ctrl_md_busy_tracker.sv | 70 +++++++
 rtl/hazard_ctrl.sv | 90 +++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: Tuse/Tnew codes,
// MUL/DIV tracker state encoding and default unit latencies.
// The optional statistics counters in hazard_ctrl are built only when
// HAZARD_CTRL_STAT_EN is defined.
package hazard_ctrl_pkg;

    // A Tuse of 3 marks an operand the D instruction never reads.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew codes carried by the producing stage.
    localparam logic [1:0] TNEW_DONE = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // Default MUL/DIV busy lengths in cycles (legal range 1..15).
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // MUL/DIV tracker states.
    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // True when a D-stage source operand must wait for a producer in E or M.
    // Register 0 is hard-wired and never creates a dependence; an unused
    // operand (Tuse = 3) can never be younger than any Tnew.
    function automatic logic operand_stall(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_wreg,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wreg,
        input logic [1:0] m_tnew
    );
        logic hit_e;
        logic hit_m;
        hit_e = (src == e_wreg) && (tuse < e_tnew);
        hit_m = (src == m_wreg) && (tuse < m_tnew);
        if ((src == 5'd0) || (tuse == TUSE_NONE)) begin
            return 1'b0;
        end
        return hit_e || hit_m;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_tracker.sv
// MUL/DIV busy tracker: a two-state FSM and a 4-bit down-counter that
// report how many more cycles the multi-cycle unit stays occupied.
// A start while already busy cannot happen in a correctly stalled pipeline
// and is ignored here.
module hazard_ctrl_md_busy_tracker
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       md_start,
    input  logic       md_is_div,
    output md_state_e  md_state,
    output logic       mdBusy,
    output logic [3:0] mdCount
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    md_state_e  state_q;
    md_state_e  state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // State and counter registers; reset drops any pending operation at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic: load on start, count down to zero while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                cnt_d = 4'd0;
                if (md_start) begin
                    cnt_d   = md_is_div ? DIV_LOAD : MULT_LOAD;
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = MD_IDLE;
            end
        endcase
    end

    assign md_state = state_q;
    assign mdBusy   = (state_q == MD_BUSY);
    assign mdCount  = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the five-stage core. Combines Tuse/Tnew
// data-hazard detection against the E and M stages with the MUL/DIV busy
// tracker, and drives the PC enable, IF/ID enable and ID/EX flush.
// Define HAZARD_CTRL_STAT_EN to add the stallCycles / mdStallCycles counters.
// The stall decision is combinational; there is no handshake on any port,
// every output is meaningful every cycle.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuseRs,
    input  logic [1:0]  D_tuseRt,
    input  logic        D_isMd,
    input  logic [4:0]  E_wReg,
    input  logic [1:0]  E_tNew,
    input  logic [4:0]  M_wReg,
    input  logic [1:0]  M_tNew,
    input  logic        E_mdStart,
    input  logic        E_mdIsDiv,
    output logic        pcEnable,
    output logic        D_regEnable,
    output logic        E_regFlush,
    output logic        mdBusy,
    output logic [3:0]  mdCount
`ifdef HAZARD_CTRL_STAT_EN
    ,
    output logic [31:0] stallCycles,
    output logic [31:0] mdStallCycles
`endif
);

    md_state_e md_state;
    logic      stall_rs;
    logic      stall_rt;
    logic      stall_md;
    logic      stall;

    hazard_ctrl_md_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_tracker (
        .clk       (clk),
        .reset     (reset),
        .md_start  (E_mdStart),
        .md_is_div (E_mdIsDiv),
        .md_state  (md_state),
        .mdBusy    (mdBusy),
        .mdCount   (mdCount)
    );

    // Stall decision: operand dependences plus any MD access while the unit
    // is occupied or being started by the instruction now in E.
    always_comb begin
        stall_rs = operand_stall(D_rs, D_tuseRs, E_wReg, E_tNew, M_wReg, M_tNew);
        stall_rt = operand_stall(D_rt, D_tuseRt, E_wReg, E_tNew, M_wReg, M_tNew);
        stall_md = D_isMd && ((md_state == MD_BUSY) || E_mdStart);
        stall    = stall_rs || stall_rt || stall_md;
    end

    // Pipeline control; while reset is low fetch and decode hold and E gets nops.
    always_comb begin
        pcEnable    = reset && !stall;
        D_regEnable = reset && !stall;
        E_regFlush  = !reset || stall;
    end

`ifdef HAZARD_CTRL_STAT_EN
    // Free-running stall statistics, wrapping at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCycles   <= 32'd0;
            mdStallCycles <= 32'd0;
        end else begin
            if (stall) begin
                stallCycles <= stallCycles + 32'd1;
            end
            if (stall_md) begin
                mdStallCycles <= mdStallCycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a driver applies one instruction mix per cycle and
// pushes the expected outputs from a cycle-indexed reference model; a
// separate monitor pops and compares every cycle.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int W     = 8;
    localparam int NMULT = DEF_MULT_CYCLES;
    localparam int NDIV  = DEF_DIV_CYCLES;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  D_rs = '0, D_rt = '0, E_wReg = '0, M_wReg = '0;
    logic [1:0]  D_tuseRs = TUSE_NONE, D_tuseRt = TUSE_NONE;
    logic [1:0]  E_tNew = TNEW_DONE, M_tNew = TNEW_DONE;
    logic        D_isMd = 1'b0, E_mdStart = 1'b0, E_mdIsDiv = 1'b0;
    logic        pcEnable, D_regEnable, E_regFlush, mdBusy;
    logic [3:0]  mdCount;
`ifdef HAZARD_CTRL_STAT_EN
    logic [31:0] stallCycles, mdStallCycles;
`endif

    hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .D_rs        (D_rs),
        .D_rt        (D_rt),
        .D_tuseRs    (D_tuseRs),
        .D_tuseRt    (D_tuseRt),
        .D_isMd      (D_isMd),
        .E_wReg      (E_wReg),
        .E_tNew      (E_tNew),
        .M_wReg      (M_wReg),
        .M_tNew      (M_tNew),
        .E_mdStart   (E_mdStart),
        .E_mdIsDiv   (E_mdIsDiv),
        .pcEnable    (pcEnable),
        .D_regEnable (D_regEnable),
        .E_regFlush  (E_regFlush),
        .mdBusy      (mdBusy),
        .mdCount     (mdCount)
`ifdef HAZARD_CTRL_STAT_EN
        ,
        .stallCycles   (stallCycles),
        .mdStallCycles (mdStallCycles)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: cycle index, index of the last busy cycle of the MD
    // unit, and stall statistics since the last reset.
    int cyc = 0;
    int md_end = -1;
    int stat_stall = 0;
    int stat_md = 0;

    function automatic logic blocked_by(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] w, input logic [1:0] tnew);
        int need;
        int ready;
        need  = tuse;
        ready = tnew;
        return (src != 5'd0) && (src == w) && (need < ready);
    endfunction

    function automatic logic model_busy();
        return cyc <= md_end;
    endfunction

    // Driver: apply one cycle of inputs and push the expected outputs.
    task automatic drive_cycle(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [1:0] tus, input logic [1:0] tut, input logic ismd,
                               input logic [4:0] ew, input logic [1:0] et,
                               input logic [4:0] mw, input logic [1:0] mt,
                               input logic start, input logic isdiv);
        logic busy, stall, smd, sdata;
        logic [3:0] cnt;
        @(negedge clk);
        #1;
        reset = rst; D_rs = rs; D_rt = rt; D_tuseRs = tus; D_tuseRt = tut; D_isMd = ismd;
        E_wReg = ew; E_tNew = et; M_wReg = mw; M_tNew = mt; E_mdStart = start; E_mdIsDiv = isdiv;
        if (!rst) begin
            md_end = cyc - 1;
            stat_stall = 0;
            stat_md = 0;
            exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
        end else begin
            busy = model_busy();
            if (start && busy) begin
                errors++;
                $display("FAIL illegal_md_start cyc=%0d: start issued while unit busy, required no start", cyc);
            end
            sdata = blocked_by(rs, tus, ew, et) || blocked_by(rs, tus, mw, mt) ||
                    blocked_by(rt, tut, ew, et) || blocked_by(rt, tut, mw, mt);
            smd   = ismd && (busy || start);
            stall = sdata || smd;
            cnt   = busy ? 4'(md_end - cyc + 1) : 4'd0;
            exp_q.push_back({!stall, !stall, stall, busy, cnt});
            if (stall) stat_stall++;
            if (smd) stat_md++;
            if (start && !busy) md_end = cyc + (isdiv ? NDIV : NMULT);
        end
        cyc++;
    endtask

    task automatic idle_cycle(input logic ismd);
        drive_cycle(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, ismd, 5'd0, TNEW_DONE, 5'd0, TNEW_DONE, 1'b0, 1'b0);
    endtask

    // Monitor: the outputs are valid every cycle; compare mid-cycle.
    initial begin
        logic [W-1:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {pcEnable, D_regEnable, E_regFlush, mdBusy, mdCount};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL outputs t=%0t {pcEn,dEn,eFlush,busy,cnt}: got %b,%b,%b,%b,%0d required %b,%b,%b,%b,%0d",
                             $time, act_v[7], act_v[6], act_v[5], act_v[4], act_v[3:0],
                             exp_v[7], exp_v[6], exp_v[5], exp_v[4], exp_v[3:0]);
                end
            end
        end
    end

    initial begin
        logic start, isdiv, rst;
        int drain;

        // Reset
        repeat (3) drive_cycle(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 1'b0, 5'd0, TNEW_DONE, 5'd0, TNEW_DONE, 1'b0, 1'b0);
        idle_cycle(1'b0);

        // Load-use on rs, then the producer goes away.
        drive_cycle(1'b1, 5'd8, 5'd0, 2'd0, TUSE_NONE, 1'b0, 5'd8, TNEW_LOAD, 5'd0, TNEW_DONE, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd8, 5'd0, 2'd0, TUSE_NONE, 1'b0, 5'd0, TNEW_LOAD, 5'd0, TNEW_DONE, 1'b0, 1'b0);
        // $0 never stalls; unused rt never stalls.
        drive_cycle(1'b1, 5'd0, 5'd0, 2'd0, TUSE_NONE, 1'b0, 5'd0, TNEW_LOAD, 5'd0, TNEW_DONE, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd0, 5'd9, TUSE_NONE, TUSE_NONE, 1'b0, 5'd0, TNEW_DONE, 5'd9, TNEW_ALU, 1'b0, 1'b0);
        // rt hazard against M with Tuse 0.
        drive_cycle(1'b1, 5'd0, 5'd9, TUSE_NONE, 2'd0, 1'b0, 5'd0, TNEW_DONE, 5'd9, TNEW_ALU, 1'b0, 1'b0);

        // Mult with dependent MD instruction held in D.
        drive_cycle(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 1'b1, 5'd0, TNEW_DONE, 5'd0, TNEW_DONE, 1'b1, 1'b0);
        repeat (NMULT + 2) idle_cycle(1'b1);

        // Div with no MD instruction in D.
        drive_cycle(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 1'b0, 5'd0, TNEW_DONE, 5'd0, TNEW_DONE, 1'b1, 1'b1);
        repeat (NDIV + 1) idle_cycle(1'b0);

        // Reset while the divider reports 6 remaining cycles.
        drive_cycle(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 1'b0, 5'd0, TNEW_DONE, 5'd0, TNEW_DONE, 1'b1, 1'b1);
        repeat (4) idle_cycle(1'b1);
        drive_cycle(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 1'b1, 5'd0, TNEW_DONE, 5'd0, TNEW_DONE, 1'b0, 1'b0);
        drive_cycle(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 1'b1, 5'd0, TNEW_DONE, 5'd0, TNEW_DONE, 1'b0, 1'b0);
        repeat (2) idle_cycle(1'b1);

        // Randomized mix.
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 79) != 0);
            start = 1'b0;
            if (!model_busy() || !rst) start = ($urandom_range(0, 5) == 0);
            isdiv = 1'(($urandom_range(0, 1)));
            drive_cycle(rst, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                        5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                        5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), start, isdiv);
        end
        idle_cycle(1'b0);

`ifdef HAZARD_CTRL_STAT_EN
        // Counters against the model after the random run.
        @(negedge clk);
        #2;
        checks++;
        if (stallCycles !== 32'(stat_stall) || mdStallCycles !== 32'(stat_md)) begin
            errors++;
            $display("FAIL stat_random: got %0d/%0d required %0d/%0d", stallCycles, mdStallCycles, stat_stall, stat_md);
        end
        // Three load-use stalls, then a mult with a dependent mfhi.
        drive_cycle(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 1'b0, 5'd0, TNEW_DONE, 5'd0, TNEW_DONE, 1'b0, 1'b0);
        repeat (3) drive_cycle(1'b1, 5'd8, 5'd0, 2'd0, TUSE_NONE, 1'b0, 5'd8, TNEW_LOAD, 5'd0, TNEW_DONE, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 1'b1, 5'd0, TNEW_DONE, 5'd0, TNEW_DONE, 1'b1, 1'b0);
        repeat (NMULT) idle_cycle(1'b1);
        idle_cycle(1'b0);
        checks++;
        if (stallCycles !== 32'd9 || mdStallCycles !== 32'd6) begin
            errors++;
            $display("FAIL stat_directed: got %0d/%0d required 9/6", stallCycles, mdStallCycles);
        end
`endif

        // Drain the scoreboard with a bounded wait.
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        #5;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
